// File: rtl/bch_dec_err_loc_seq_pkg.sv
// Field helpers, state and status encodings for the DEC BCH error locator.
// Primitive polynomials match the syndrome generator for m = 5..8.
package bch_dec_err_loc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SQ,
      ST_CU,
      ST_INIT,
      ST_SRCH,
      ST_DONE
   } state_t;

   localparam logic [1:0] STAT_NONE = 2'b00;
   localparam logic [1:0] STAT_ONE  = 2'b01;
   localparam logic [1:0] STAT_TWO  = 2'b10;
   localparam logic [1:0] STAT_UNC  = 2'b11;

   // Low m bits of the primitive polynomial (x^m term implied).
   function automatic logic [7:0] fn_prim(input int m);
      logic [7:0] p;
      case (m)
         5:       p = 8'h05;
         6:       p = 8'h03;
         7:       p = 8'h09;
         default: p = 8'h1D;
      endcase
      return p;
   endfunction

   function automatic logic [7:0] fn_mul_a(input logic [7:0] a,
                                           input int m);
      logic [7:0] mask;
      logic [7:0] r;
      logic [2:0] top;
      mask = 8'hFF >> (8 - m);
      top  = 3'(m - 1);
      r    = (a << 1) & mask;
      if (a[top]) r = r ^ fn_prim(m);
      return r;
   endfunction

   function automatic logic [7:0] fn_mul_a2(input logic [7:0] a,
                                            input int m);
      return fn_mul_a(fn_mul_a(a, m), m);
   endfunction

   function automatic int fn_int_width(input int m);
      return (1 << m) - 1;
   endfunction

   function automatic int fn_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/bch_dec_err_loc_seq_gf_mult_univ.sv
// Combinational general GF(2^m) multiplier, MSB-first shift-and-add.
// Shared by the square and cube steps of the error locator.
module gf_mult_univ
   import bch_dec_err_loc_seq_pkg::*;
#(
   parameter int P_GF_M = 5
) (
   input  logic [P_GF_M-1:0] a_i,
   input  logic [P_GF_M-1:0] b_i,
   output logic [P_GF_M-1:0] p_o
);

   logic [7:0] a8;
   logic [7:0] acc;

   always_comb begin
      a8 = '0;
      a8[P_GF_M-1:0] = a_i;
      acc = '0;
      for (int i = P_GF_M - 1; i >= 0; i--) begin
         acc = fn_mul_a(acc, P_GF_M);
         if (b_i[i]) acc = acc ^ a8;
      end
      p_o = acc[P_GF_M-1:0];
   end

endmodule

// File: rtl/bch_dec_err_loc_seq.sv
// Sequential DEC BCH error locator: division-free degree-2 locator
// followed by a one-position-per-cycle Chien search.
module bch_dec_err_loc_seq
   import bch_dec_err_loc_seq_pkg::*;
#(
   parameter int P_D_WIDTH = 16,
   parameter int P_GF_M    = 5,
   localparam int LP_CW_WIDTH = P_D_WIDTH + 2 * P_GF_M,
   localparam int LP_POS_W    = fn_clog2(LP_CW_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  synd_vld_i,
   input  logic [2*P_GF_M-1:0]   synd_i,
   output logic                  synd_rdy_o,
   output logic                  err_vld_o,
   output logic [LP_POS_W-1:0]   err_pos_o,
   output logic                  done_o,
   output logic [1:0]            status_o
);

   localparam int LP_N   = fn_int_width(P_GF_M);
   localparam int LP_OFF = LP_N - LP_CW_WIDTH;
   localparam logic [P_GF_M-1:0] LP_J_TOP = P_GF_M'(LP_N - 1);
   localparam logic [P_GF_M-1:0] LP_J_END = P_GF_M'(LP_OFF);

   function automatic logic [P_GF_M-1:0] mul_a1(
      input logic [P_GF_M-1:0] v);
      logic [7:0] t;
      t = '0;
      t[P_GF_M-1:0] = v;
      t = fn_mul_a(t, P_GF_M);
      return t[P_GF_M-1:0];
   endfunction

   function automatic logic [P_GF_M-1:0] mul_a2(
      input logic [P_GF_M-1:0] v);
      logic [7:0] t;
      t = '0;
      t[P_GF_M-1:0] = v;
      t = fn_mul_a2(t, P_GF_M);
      return t[P_GF_M-1:0];
   endfunction

   state_t state_q, state_d;

   logic [P_GF_M-1:0]   s1_q, s1_d;
   logic [P_GF_M-1:0]   s3_q, s3_d;
   logic [P_GF_M-1:0]   sq_q, sq_d;
   logic [P_GF_M-1:0]   cu_q, cu_d;
   logic [P_GF_M-1:0]   sig0_q, sig0_d;
   logic [P_GF_M-1:0]   r1_q, r1_d;
   logic [P_GF_M-1:0]   r2_q, r2_d;
   logic [P_GF_M-1:0]   j_q, j_d;
   logic [1:0]          found_q, found_d;
   logic [1:0]          exp_q, exp_d;
   logic [1:0]          status_q, status_d;
   logic [LP_POS_W-1:0] pos_q, pos_d;

   logic [P_GF_M-1:0]   mul_a;
   logic [P_GF_M-1:0]   mul_p;
   logic [P_GF_M-1:0]   j_rel;
   logic [LP_POS_W-1:0] cur_pos;
   logic                hit;

   // One multiplier serves both S1*S1 and sq*S1.
   assign mul_a = (state_q == ST_CU) ? sq_q : s1_q;

   gf_mult_univ #(
      .P_GF_M (P_GF_M)
   ) u_mult (
      .a_i (mul_a),
      .b_i (s1_q),
      .p_o (mul_p)
   );

   assign j_rel   = j_q - LP_J_END;
   assign cur_pos = j_rel[LP_POS_W-1:0];
   assign hit     = (state_q == ST_SRCH) &&
                    ((sig0_q ^ r1_q ^ r2_q) == '0);

   assign synd_rdy_o = (state_q == ST_IDLE);
   assign err_vld_o  = hit;
   assign err_pos_o  = hit ? cur_pos : pos_q;
   assign done_o     = (state_q == ST_DONE);
   assign status_o   = status_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         s1_q     <= '0;
         s3_q     <= '0;
         sq_q     <= '0;
         cu_q     <= '0;
         sig0_q   <= '0;
         r1_q     <= '0;
         r2_q     <= '0;
         j_q      <= '0;
         found_q  <= '0;
         exp_q    <= '0;
         status_q <= STAT_NONE;
         pos_q    <= '0;
      end else begin
         state_q  <= state_d;
         s1_q     <= s1_d;
         s3_q     <= s3_d;
         sq_q     <= sq_d;
         cu_q     <= cu_d;
         sig0_q   <= sig0_d;
         r1_q     <= r1_d;
         r2_q     <= r2_d;
         j_q      <= j_d;
         found_q  <= found_d;
         exp_q    <= exp_d;
         status_q <= status_d;
         pos_q    <= pos_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      s1_d     = s1_q;
      s3_d     = s3_q;
      sq_d     = sq_q;
      cu_d     = cu_q;
      sig0_d   = sig0_q;
      r1_d     = r1_q;
      r2_d     = r2_q;
      j_d      = j_q;
      found_d  = found_q;
      exp_d    = exp_q;
      status_d = status_q;
      pos_d    = pos_q;
      unique case (state_q)
         ST_IDLE: begin
            if (synd_vld_i) begin
               s1_d    = synd_i[P_GF_M-1:0];
               s3_d    = synd_i[2*P_GF_M-1:P_GF_M];
               state_d = ST_SQ;
            end
         end
         ST_SQ: begin
            sq_d    = mul_p;
            state_d = ST_CU;
         end
         ST_CU: begin
            cu_d    = mul_p;
            state_d = ST_INIT;
         end
         ST_INIT: begin
            found_d = '0;
            if (s1_q == '0) begin
               exp_d    = '0;
               status_d = (s3_q == '0) ? STAT_NONE : STAT_UNC;
               state_d  = ST_DONE;
            end else begin
               // Locator scaled by S1: S1 + S1^2 x + (S3+S1^3) x^2.
               sig0_d  = s1_q;
               r1_d    = mul_a1(sq_q);
               r2_d    = mul_a2(s3_q ^ cu_q);
               exp_d   = (s3_q == cu_q) ? 2'd1 : 2'd2;
               j_d     = LP_J_TOP;
               state_d = ST_SRCH;
            end
         end
         ST_SRCH: begin
            found_d = found_q + {1'b0, hit};
            r1_d    = mul_a1(r1_q);
            r2_d    = mul_a2(r2_q);
            j_d     = j_q - P_GF_M'(1);
            if (hit) pos_d = cur_pos;
            if ((hit && found_d == exp_q) || j_q == LP_J_END) begin
               status_d = (found_d == exp_q) ? exp_q : STAT_UNC;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bch_dec_err_loc_seq.sv
// Directed bench for the DEC BCH error locator, m=5, 16 data bits.
// Syndromes below are hand-derived from x^5+x^2+1 power tables.
module tb_bch_dec_err_loc_seq;

   logic       clk;
   logic       rst_i;
   logic       synd_vld_i;
   logic [9:0] synd_i;
   logic       synd_rdy_o;
   logic       err_vld_o;
   logic [4:0] err_pos_o;
   logic       done_o;
   logic [1:0] status_o;

   int checks   = 0;
   int failures = 0;

   // {S3,S1}
   localparam logic [9:0] SYN_ZERO   = 10'b00000_00000;
   localparam logic [9:0] SYN_S1Z    = 10'b00001_00000;
   localparam logic [9:0] SYN_SINGLE = 10'b11111_00101;
   localparam logic [9:0] SYN_DOUBLE = 10'b01000_11111;
   localparam logic [9:0] SYN_TRIPLE = 10'b00101_10011;

   bch_dec_err_loc_seq #(
      .P_D_WIDTH (16),
      .P_GF_M    (5)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .synd_vld_i (synd_vld_i),
      .synd_i     (synd_i),
      .synd_rdy_o (synd_rdy_o),
      .err_vld_o  (err_vld_o),
      .err_pos_o  (err_pos_o),
      .done_o     (done_o),
      .status_o   (status_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic decode(input logic [9:0] syn, output int lat,
                         output int nerr, output int p0, output int p1,
                         output bit desc);
      int last;
      int w;
      lat = -1; nerr = 0; p0 = -1; p1 = -1; desc = 1'b1;
      last = 1 << 20; w = 0;
      @(negedge clk);
      while (synd_rdy_o !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      synd_i = syn;
      synd_vld_i = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1 synd_vld_i = 1'b0;
         @(negedge clk);
         if (err_vld_o === 1'b1) begin
            if (int'(err_pos_o) >= last) desc = 1'b0;
            last = int'(err_pos_o);
            if (nerr == 0) p0 = int'(err_pos_o);
            if (nerr == 1) p1 = int'(err_pos_o);
            nerr++;
         end
         if (done_o === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      synd_vld_i = 1'b0;
      synd_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (synd_rdy_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_rdy got=%0b exp=1", synd_rdy_o);
      end
      checks++;
      if (err_vld_o !== 1'b0 || done_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_pulses got=%0b%0b exp=00", err_vld_o, done_o);
      end
      checks++;
      if (err_pos_o !== 5'd0 || status_o !== 2'b00) begin
         failures++;
         $display("FAIL reset_regs pos=%0d st=%0b exp=0/00",
                  err_pos_o, status_o);
      end
      @(posedge clk);
      #1 rst_i = 1'b0;
   endtask

   task automatic test_zero();
      int lat, nerr, p0, p1;
      bit desc;
      decode(SYN_ZERO, lat, nerr, p0, p1, desc);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL zero_lat got=%0d exp=4", lat);
      end
      checks++;
      if (status_o !== 2'b00 || nerr !== 0) begin
         failures++;
         $display("FAIL zero_status st=%0b nerr=%0d exp=00/0", status_o, nerr);
      end
   endtask

   task automatic test_s1_zero();
      int lat, nerr, p0, p1;
      bit desc;
      decode(SYN_S1Z, lat, nerr, p0, p1, desc);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL s1z_lat got=%0d exp=4", lat);
      end
      checks++;
      if (status_o !== 2'b11 || nerr !== 0) begin
         failures++;
         $display("FAIL s1z_status st=%0b nerr=%0d exp=11/0", status_o, nerr);
      end
   endtask

   task automatic test_single();
      int lat, nerr, p0, p1;
      bit desc;
      decode(SYN_SINGLE, lat, nerr, p0, p1, desc);
      checks++;
      if (nerr !== 1 || p0 !== 0) begin
         failures++;
         $display("FAIL single_pos nerr=%0d pos=%0d exp=1/0", nerr, p0);
      end
      checks++;
      if (status_o !== 2'b01) begin
         failures++;
         $display("FAIL single_status got=%0b exp=01", status_o);
      end
      checks++;
      if (lat !== 30) begin
         failures++;
         $display("FAIL single_lat got=%0d exp=30", lat);
      end
   endtask

   task automatic test_double();
      int lat, nerr, p0, p1;
      bit desc;
      decode(SYN_DOUBLE, lat, nerr, p0, p1, desc);
      checks++;
      if (nerr !== 2 || p0 !== 25 || p1 !== 3) begin
         failures++;
         $display("FAIL double_pos nerr=%0d p0=%0d p1=%0d exp=2/25/3",
                  nerr, p0, p1);
      end
      checks++;
      if (status_o !== 2'b10 || desc !== 1'b1) begin
         failures++;
         $display("FAIL double_status st=%0b desc=%0b exp=10/1",
                  status_o, desc);
      end
      checks++;
      if (lat !== 27) begin
         failures++;
         $display("FAIL double_early_exit lat=%0d exp=27", lat);
      end
      checks++;
      if (err_pos_o !== 5'd3) begin
         failures++;
         $display("FAIL double_pos_hold got=%0d exp=3", err_pos_o);
      end
   endtask

   task automatic test_triple();
      int lat, nerr, p0, p1;
      bit desc;
      decode(SYN_TRIPLE, lat, nerr, p0, p1, desc);
      checks++;
      if (nerr == 2 || nerr !== 0) begin
         failures++;
         $display("FAIL triple_nerr got=%0d exp=0", nerr);
      end
      checks++;
      if (status_o !== 2'b11) begin
         failures++;
         $display("FAIL triple_status got=%0b exp=11", status_o);
      end
      checks++;
      if (lat !== 30) begin
         failures++;
         $display("FAIL triple_lat got=%0d exp=30", lat);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      int dn;
      w = 0;
      dn = 0;
      @(negedge clk);
      while (synd_rdy_o !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      synd_i = SYN_SINGLE;
      synd_vld_i = 1'b1;
      @(posedge clk);
      #1 synd_vld_i = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      checks++;
      if (synd_rdy_o !== 1'b1 || done_o !== 1'b0) begin
         failures++;
         $display("FAIL midrst_ctrl rdy=%0b done=%0b exp=1/0",
                  synd_rdy_o, done_o);
      end
      checks++;
      if (err_vld_o !== 1'b0 || err_pos_o !== 5'd0 || status_o !== 2'b00) begin
         failures++;
         $display("FAIL midrst_regs vld=%0b pos=%0d st=%0b exp=0/0/00",
                  err_vld_o, err_pos_o, status_o);
      end
      repeat (40) begin
         @(negedge clk);
         if (done_o === 1'b1) dn++;
      end
      checks++;
      if (dn !== 0) begin
         failures++;
         $display("FAIL midrst_no_done got=%0d exp=0", dn);
      end
   endtask

   task automatic test_back_to_back();
      int w;
      int nerr;
      int done2;
      w = 0;
      nerr = 0;
      done2 = -1;
      @(negedge clk);
      while (synd_rdy_o !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      synd_i = SYN_S1Z;
      synd_vld_i = 1'b1;
      @(posedge clk);
      #1 synd_i = SYN_DOUBLE;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c < 4) begin
            checks++;
            if (synd_rdy_o !== 1'b0) begin
               failures++;
               $display("FAIL b2b_busy c=%0d rdy=%0b exp=0", c, synd_rdy_o);
            end
         end
         if (c == 4) begin
            checks++;
            if (done_o !== 1'b1 || status_o !== 2'b11 || synd_rdy_o !== 1'b0) begin
               failures++;
               $display("FAIL b2b_done1 done=%0b st=%0b rdy=%0b exp=1/11/0",
                        done_o, status_o, synd_rdy_o);
            end
         end
         if (c == 5) begin
            checks++;
            if (synd_rdy_o !== 1'b1 || status_o !== 2'b11 || done_o !== 1'b0) begin
               failures++;
               $display("FAIL b2b_accept rdy=%0b st=%0b done=%0b exp=1/11/0",
                        synd_rdy_o, status_o, done_o);
            end
         end
         if (c > 5 && err_vld_o === 1'b1) nerr++;
         if (c > 5 && done_o === 1'b1) begin
            done2 = c;
            break;
         end
         @(posedge clk);
         if (c == 5) #1 synd_vld_i = 1'b0;
      end
      synd_vld_i = 1'b0;
      checks++;
      if (done2 !== 32) begin
         failures++;
         $display("FAIL b2b_done2 cycle=%0d exp=32", done2);
      end
      checks++;
      if (status_o !== 2'b10 || nerr !== 2) begin
         failures++;
         $display("FAIL b2b_status2 st=%0b nerr=%0d exp=10/2", status_o, nerr);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      synd_vld_i = 1'b0;
      synd_i = '0;
      test_reset();
      test_zero();
      test_s1_zero();
      test_single();
      test_double();
      test_triple();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
